// File: rtl/cmd_rsp_pkg.sv
// Shared types and constants for the UART command responder.
package cmd_rsp_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        DLY,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [7:0] CMD_TERM  = 8'h0D;
    localparam logic [7:0] RESP_TERM = 8'h0A;
    localparam logic [7:0] OK_B0     = 8'h4F;
    localparam logic [7:0] OK_B1     = 8'h4B;
    localparam logic [7:0] ER_B0     = 8'h45;
    localparam logic [7:0] ER_B1     = 8'h52;

    localparam int BUF_DEPTH = 16;
    // clk cycles per UART bit
    localparam int BAUD_DIV  = 16;

    function automatic logic [7:0] resp_byte(input logic er, input logic [1:0] idx);
        case (idx)
            2'd0:    resp_byte = er ? ER_B0 : OK_B0;
            2'd1:    resp_byte = er ? ER_B1 : OK_B1;
            default: resp_byte = RESP_TERM;
        endcase
    endfunction

endpackage

// File: rtl/cmd_rsp_uart.sv
// 8N1 UART: one transmitter and one receiver sharing a fixed baud divisor.
module cmd_rsp_uart #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data
);

    localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

    logic [9:0]  tx_shft;
    logic [3:0]  tx_bits;
    logic [15:0] tx_baud;
    logic        tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft <= '1;
            tx_bits <= '0;
            tx_baud <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else if (trmt) begin
            tx_shft <= {1'b1, tx_data, 1'b0};
            tx_bits <= '0;
            tx_baud <= '0;
            tx_busy <= 1'b1;
            tx_done <= 1'b0;
        end else if (tx_busy) begin
            if (tx_baud == DIV_M1) begin
                tx_baud <= '0;
                tx_shft <= {1'b1, tx_shft[9:1]};
                if (tx_bits == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bits <= tx_bits + 4'd1;
                end
            end else begin
                tx_baud <= tx_baud + 16'd1;
            end
        end
    end

    assign TX = tx_shft[0];

    logic        rx_s1, rx_s2;
    logic [9:0]  rx_shft;
    logic [3:0]  rx_bits;
    logic [15:0] rx_baud;
    logic        rx_busy;

    // Samples start, 8 data and stop at mid-bit; frame lands in rx_shft[9:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_shft <= '0;
            rx_bits <= '0;
            rx_baud <= '0;
            rx_busy <= 1'b0;
            rx_rdy  <= 1'b0;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            if (clr_rx_rdy)
                rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_baud <= HALF_M1;
                    rx_bits <= '0;
                end
            end else if (rx_baud == 16'd0) begin
                rx_shft <= {rx_s2, rx_shft[9:1]};
                rx_baud <= DIV_M1;
                if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_rdy  <= 1'b1;
                end else begin
                    rx_bits <= rx_bits + 4'd1;
                end
            end else begin
                rx_baud <= rx_baud - 16'd1;
            end
        end
    end

    assign rx_data = rx_shft[8:1];

endmodule

// File: rtl/cmd_rsp.sv
// Command responder: buffers RX bytes up to CR, publishes the command and answers OK/ER on TX.
module cmd_rsp
    import cmd_rsp_pkg::*;
#(
    parameter int RESP_DLY = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       cmd_rdy,
    output logic [4:0] cmd_len,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       resp_busy
);

    localparam logic [4:0] BUF_FULL = 5'(BUF_DEPTH);
    localparam logic [7:0] DLY_END  = 8'(RESP_DLY);

    state_t     state, state_nxt;
    logic [7:0] cmd_buf [BUF_DEPTH];
    logic [4:0] cnt;
    logic       ovf;
    logic [7:0] dly;
    logic [1:0] idx;
    logic       resp_er;

    logic       trmt, tx_done, rx_rdy;
    logic [7:0] tx_data, rx_data;
    logic       term_hit;

    cmd_rsp_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (rx_rdy),
        .rx_data    (rx_data)
    );

    assign term_hit = rx_rdy && (rx_data == CMD_TERM);
    assign rd_data  = cmd_buf[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        trmt      = 1'b0;
        tx_data   = resp_byte(resp_er, idx);
        resp_busy = (state != COLLECT);
        case (state)
            COLLECT: if (term_hit) state_nxt = DLY;
            // dly is 0 in the cmd_rdy cycle; SEND lands RESP_DLY+1 cycles later
            DLY:     if (dly == DLY_END) state_nxt = SEND;
            SEND: begin
                trmt      = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: if (tx_done) state_nxt = (idx == 2'd2) ? COLLECT : SEND;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++)
                cmd_buf[i] <= 8'h00;
            cnt     <= '0;
            ovf     <= 1'b0;
            dly     <= '0;
            idx     <= '0;
            resp_er <= 1'b0;
            cmd_rdy <= 1'b0;
            cmd_len <= '0;
        end else begin
            cmd_rdy <= 1'b0;
            case (state)
                COLLECT: begin
                    if (term_hit) begin
                        if (!ovf) begin
                            cmd_len <= cnt;
                            cmd_rdy <= 1'b1;
                        end
                        resp_er <= ovf;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        dly     <= '0;
                        idx     <= '0;
                    end else if (rx_rdy) begin
                        if (cnt < BUF_FULL) begin
                            cmd_buf[cnt[3:0]] <= rx_data;
                            cnt               <= cnt + 5'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                DLY:     dly <= dly + 8'd1;
                WAIT_TX: if (tx_done && idx != 2'd2) idx <= idx + 2'd1;
                default: ;
            endcase
        end
    end

endmodule
